// File: rtl/fc_sequencer_pkg.sv
// Shared sizes, state encoding and helpers for the final FC layer sequencer.
package cnn_fc_pkg;
  localparam int INPUT_NUM  = 48;
  localparam int OUTPUT_NUM = 10;
  localparam int LANES      = 3;
  localparam int DATA_BITS  = 8;
  localparam int IN_BITS    = 12;
  localparam int ACC_BITS   = 20;

  // Buffered samples carry two extra sign bits so the MAC sees 8x14 products.
  localparam int BUF_BITS   = IN_BITS + 2;
  localparam int BEATS      = INPUT_NUM / LANES;
  localparam int OUT_MSB    = 18;
  localparam int OUT_LSB    = 7;
  localparam int OUT_BITS   = OUT_MSB - OUT_LSB + 1;

  localparam int WADDR_BITS = 9;
  localparam int BADDR_BITS = 4;
  localparam int STEP_BITS  = 6;
  localparam int BEAT_BITS  = 4;
  localparam int OIDX_BITS  = 4;

  typedef enum logic [1:0] {LOAD, MAC, OUT} fc_state_e;

  // First weight of class o in the flattened o*48+i ROM layout.
  function automatic logic [WADDR_BITS-1:0] row_base(input logic [OIDX_BITS-1:0] o);
    return WADDR_BITS'(o) * WADDR_BITS'(INPUT_NUM);
  endfunction
endpackage

// File: rtl/fc_sequencer_if.sv
// Lane input, weight/bias ROM and score output signals of the FC sequencer.
interface fc_sequencer_if;
  import cnn_fc_pkg::*;

  logic                  valid_in;
  logic                  in_ready;
  logic [IN_BITS-1:0]    data_in_1;
  logic [IN_BITS-1:0]    data_in_2;
  logic [IN_BITS-1:0]    data_in_3;
  logic [WADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0]  w_data;
  logic [BADDR_BITS-1:0] b_addr;
  logic [DATA_BITS-1:0]  b_data;
  logic [OUT_BITS-1:0]   data_out;
  logic                  valid_out;
  logic                  out_ready;
  logic [OIDX_BITS-1:0]  out_idx;
  logic                  last_out;

  // Sequencer side.
  modport slave (
    input  valid_in, data_in_1, data_in_2, data_in_3, w_data, b_data, out_ready,
    output in_ready, w_addr, b_addr, data_out, valid_out, out_idx, last_out
  );

  // Upstream / ROM / downstream side.
  modport master (
    output valid_in, data_in_1, data_in_2, data_in_3, w_data, b_data, out_ready,
    input  in_ready, w_addr, b_addr, data_out, valid_out, out_idx, last_out
  );
endinterface

// File: rtl/fc_sequencer_mac.sv
// Shared signed 8x14 multiply-accumulate with clear and bias injection.
// The accumulator wraps at ACC_BITS; its next value is exported so the
// sequencer can capture the final score on the same edge it completes.
module fc_mac
  import cnn_fc_pkg::*;
(
  input  logic                        clk,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic                        bias_en_i,
  input  logic signed [DATA_BITS-1:0] w_i,
  input  logic signed [DATA_BITS-1:0] b_i,
  input  logic signed [BUF_BITS-1:0]  x_i,
  output logic signed [ACC_BITS-1:0]  acc_d_o
);
  logic signed [DATA_BITS+BUF_BITS-1:0] prod;
  logic signed [ACC_BITS-1:0]           prod_w;
  logic signed [ACC_BITS-1:0]           bias_w;
  logic signed [ACC_BITS-1:0]           acc_q;
  logic signed [ACC_BITS-1:0]           acc_d;

  // Next accumulator value: clear, or add product (plus bias on the first term).
  always_comb begin
    prod   = w_i * x_i;
    prod_w = prod[ACC_BITS-1:0];
    bias_w = ACC_BITS'(b_i);
    acc_d  = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q + prod_w + (bias_en_i ? bias_w : '0);
  end

  // Accumulator register; always cleared before use, so no reset needed.
  always_ff @(posedge clk)
    acc_q <= acc_d;

  assign acc_d_o = acc_d;
endmodule

// File: rtl/fc_sequencer.sv
// Final FC layer controller: buffers 16 three-lane beats, then runs one
// shared MAC over the weight/bias ROM for each of the 10 classes and hands
// the scores out one at a time on valid/ready.
module fc_sequencer
  import cnn_fc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fc_sequencer_if.slave   bus
);
  localparam logic [STEP_BITS-1:0] STEP_END  = STEP_BITS'(INPUT_NUM);
  localparam logic [STEP_BITS-1:0] STEP_WEND = STEP_BITS'(INPUT_NUM - 1);
  localparam logic [BEAT_BITS-1:0] BEAT_END  = BEAT_BITS'(BEATS - 1);
  localparam logic [OIDX_BITS-1:0] O_LAST    = OIDX_BITS'(OUTPUT_NUM - 1);

  fc_state_e               state_q;
  logic [BEAT_BITS-1:0]    beat_q;
  logic [STEP_BITS-1:0]    step_q;
  logic [OIDX_BITS-1:0]    o_q;
  logic                    in_ready_q;
  logic                    valid_out_q;
  logic                    last_q;
  logic [OUT_BITS-1:0]     data_out_q;
  logic [WADDR_BITS-1:0]   w_addr_q;
  logic [BADDR_BITS-1:0]   b_addr_q;

  logic signed [BUF_BITS-1:0] buf_q [INPUT_NUM];
  logic signed [IN_BITS-1:0]  lane_x [LANES];

  logic                       load_fire;
  logic [STEP_BITS-1:0]       rd_idx;
  logic                       mac_clr, mac_en, mac_bias;
  logic signed [ACC_BITS-1:0] acc_d;

  // Lane view of the input bus and MAC step decode.
  always_comb begin
    lane_x[0] = signed'(bus.data_in_1);
    lane_x[1] = signed'(bus.data_in_2);
    lane_x[2] = signed'(bus.data_in_3);
    load_fire = (state_q == LOAD) && bus.valid_in && in_ready_q;
    // Step c multiplies buffer[c-1]; step 0 only clears.
    rd_idx    = (step_q == '0) ? '0 : step_q - STEP_BITS'(1);
    mac_clr   = (state_q == MAC) && (step_q == '0);
    mac_en    = (state_q == MAC) && (step_q != '0);
    mac_bias  = (step_q == STEP_BITS'(1));
  end

  // Sample buffer: lane k of beat b lands at entry k*16+b, sign-extended.
  always_ff @(posedge clk)
    if (load_fire)
      for (int k = 0; k < LANES; k++)
        buf_q[{2'(k), beat_q}] <= BUF_BITS'(lane_x[k]);

  fc_mac u_mac (
    .clk       (clk),
    .clr_i     (mac_clr),
    .en_i      (mac_en),
    .bias_en_i (mac_bias),
    .w_i       (signed'(bus.w_data)),
    .b_i       (signed'(bus.b_data)),
    .x_i       (buf_q[rd_idx]),
    .acc_d_o   (acc_d)
  );

  // Sequencer FSM with registered handshake, address and score outputs.
  // Addresses are loaded on entry to MAC so ROM data lines up with step c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      beat_q      <= '0;
      step_q      <= '0;
      o_q         <= '0;
      in_ready_q  <= 1'b1;
      valid_out_q <= 1'b0;
      last_q      <= 1'b0;
      data_out_q  <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_fire) begin
            if (beat_q == BEAT_END) begin
              beat_q     <= '0;
              o_q        <= '0;
              step_q     <= '0;
              w_addr_q   <= row_base('0);
              b_addr_q   <= '0;
              in_ready_q <= 1'b0;
              state_q    <= MAC;
            end else begin
              beat_q <= beat_q + BEAT_BITS'(1);
            end
          end
        end
        MAC: begin
          if (step_q == STEP_END) begin
            step_q      <= '0;
            valid_out_q <= 1'b1;
            last_q      <= (o_q == O_LAST);
            data_out_q  <= acc_d[OUT_MSB:OUT_LSB];
            state_q     <= OUT;
          end else begin
            step_q <= step_q + STEP_BITS'(1);
            // Hold the address at o*48+47 through the final step.
            if (step_q < STEP_WEND)
              w_addr_q <= w_addr_q + WADDR_BITS'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            valid_out_q <= 1'b0;
            last_q      <= 1'b0;
            if (o_q == O_LAST) begin
              in_ready_q <= 1'b1;
              state_q    <= LOAD;
            end else begin
              o_q      <= o_q + OIDX_BITS'(1);
              w_addr_q <= row_base(o_q + OIDX_BITS'(1));
              b_addr_q <= BADDR_BITS'(o_q + OIDX_BITS'(1));
              state_q  <= MAC;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.valid_out = valid_out_q;
  assign bus.last_out  = last_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_idx   = o_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.b_addr    = b_addr_q;
endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: synchronous weight/bias ROMs, constant
// and mixed frames, output stall, and reset in the middle of a class.
module tb_fc_sequencer;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   k;

  logic signed [7:0]  wrom [480];
  logic signed [7:0]  brom [16];
  logic signed [11:0] samp [48];
  logic [11:0]        exp_sc [10];

  fc_sequencer_if bus ();

  fc_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROMs with one cycle of read latency.
  always @(posedge clk) begin
    bus.w_data <= wrom[bus.w_addr];
    bus.b_data <= brom[bus.b_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic set_rom(input logic signed [7:0] w, input logic signed [7:0] b);
    for (int i = 0; i < 480; i++) wrom[i] = w;
    for (int i = 0; i < 16; i++)  brom[i] = b;
  endtask

  task automatic fill(input logic [11:0] s, input logic [11:0] sc);
    for (int i = 0; i < 48; i++) samp[i] = s;
    for (int o = 0; o < 10; o++) exp_sc[o] = sc;
  endtask

  // Reference score: full-precision dot product plus bias, then bits 18:7.
  function automatic logic [11:0] golden(input int o);
    int a;
    a = int'(brom[o]);
    for (int i = 0; i < 48; i++) a += int'(wrom[o*48 + i]) * int'(samp[i]);
    return a[18:7];
  endfunction

  task automatic load_frame();
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      bus.valid_in  = 1'b1;
      bus.data_in_1 = samp[b];
      bus.data_in_2 = samp[16 + b];
      bus.data_in_3 = samp[32 + b];
      @(posedge clk);
    end
    #1 bus.valid_in = 1'b0;
  endtask

  // Collect ten scores; optionally stall one class or reset during one.
  task automatic run_scores(input int stall_cls, input int rst_cls);
    for (int o = 0; o < 10; o++) begin
      if (o == rst_cls) begin
        repeat (21) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.valid_out && k < 200);
      chk("latency", 32'(k), 32'd50);
      chk("score", 32'(bus.data_out), 32'(exp_sc[o]));
      chk("out_idx", 32'(bus.out_idx), 32'(o));
      chk("last_out", 32'(bus.last_out), 32'(o == 9));
      if (o == stall_cls) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 20; s++) begin
          @(negedge clk);
          bus.valid_in  = s[0];
          bus.data_in_1 = 12'h7FF;
          bus.data_in_2 = 12'h800;
          bus.data_in_3 = 12'h123;
          chk("hold_data", 32'(bus.data_out), 32'(exp_sc[o]));
          chk("hold_idx", 32'(bus.out_idx), 32'(o));
          chk("hold_valid_in_ready", {30'd0, bus.valid_out, bus.in_ready}, 32'd2);
        end
        bus.valid_in  = 1'b0;
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("frame_done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("frame_done_valid", 32'(bus.valid_out), 32'd0);
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_in_1 = '0;
    bus.data_in_2 = '0;
    bus.data_in_3 = '0;
    set_rom(8'sd0, 8'sd0);
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset_last_out", 32'(bus.last_out), 32'd0);
    chk("reset_out_idx", 32'(bus.out_idx), 32'd0);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    chk("reset_w_addr", 32'(bus.w_addr), 32'd0);
    chk("reset_b_addr", 32'(bus.b_addr), 32'd0);
    rst = 1'b0;

    // 48 * 128 = 6144 -> 0x030
    set_rom(8'sd1, 8'sd0);
    fill(12'h080, 12'h030);
    load_frame();
    run_scores(-1, -1);

    // -6144 -> 0xFD0
    fill(12'hF80, 12'hFD0);
    load_frame();
    run_scores(-1, -1);

    // 2*6144 - 128 = 12160 -> 0x05F
    set_rom(8'sd2, -8'sd128);
    fill(12'h080, 12'h05F);
    load_frame();
    run_scores(-1, -1);

    // 2047*127*48 wraps to 944176 -> 0xCD0; stall class 3
    set_rom(8'sd127, 8'sd0);
    fill(12'd2047, 12'hCD0);
    load_frame();
    run_scores(3, -1);

    // Reset at MAC step 20 of class 5, then a fresh mixed frame
    set_rom(8'sd1, 8'sd0);
    fill(12'h080, 12'h030);
    load_frame();
    run_scores(-1, 5);

    for (int i = 0; i < 480; i++) wrom[i] = 8'((i * 29 + 11) % 256);
    for (int o = 0; o < 16; o++)  brom[o] = 8'(o * 23 - 100);
    for (int i = 0; i < 48; i++)  samp[i] = 12'(i * 173 - 4000);
    for (int o = 0; o < 10; o++)  exp_sc[o] = golden(o);
    load_frame();
    run_scores(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fc_sequencer.md
# fc_sequencer

Time-multiplexed controller for the CNN's final fully connected layer (48 inputs, 10 classes). It collects the three 12-bit lane streams from the last pooling stage into a 48-entry buffer. It then sequences one shared multiply-accumulate over an addressed weight/bias ROM, producing the 10 class scores one at a time on a valid/ready output. This replaces the 480-multiplier flat sum with a single MAC and removes the 3840-bit weight bus, while keeping results bit-exact with the existing layer.

## Interface
- INPUT_NUM, 48, inputs per frame
- OUTPUT_NUM, 10, class scores per frame
- LANES, 3, input samples accepted per beat
- DATA_BITS, 8, signed weight/bias width
- IN_BITS, 12, signed input sample width
- ACC_BITS, 20, accumulator width (two's-complement wrap)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  lane data valid
- in_ready  out  1  buffer accepting beats
- data_in_1, data_in_2, data_in_3  in  12 each  signed samples, lane k
- w_addr  out  9  weight ROM address, o*48+i
- w_data  in  8  signed weight, valid one cycle after w_addr
- b_addr  out  4  bias ROM address
- b_data  in  8  signed bias, valid one cycle after b_addr
- data_out  out  12  class score, acc[18:7]
- valid_out  out  1  score valid
- out_ready  in  1  downstream accepts score
- out_idx  out  4  class index of data_out, 0..9
- last_out  out  1  high with valid_out on class 9

## Operation
- States: LOAD, MAC, OUT. Reset state is LOAD.
- LOAD:
  - in_ready=1. A beat is accepted when valid_in&&in_ready.
  - Beat b (0..15) writes buffer[b], buffer[16+b] and buffer[32+b] from lanes 1, 2 and 3. Each sample is sign-extended to 14 bits.
  - On beat 15: beat counter wraps to 0, class index o<=0, go to MAC.
- MAC, step counter c=0..48:
  - c=0: acc<=0, drive w_addr=o*48, b_addr=o.
  - c=1..47: drive w_addr=o*48+c. acc+=w_data*buffer[c-1]. At c=1 also add sext(b_data).
  - c=48: acc+=w_data*buffer[47], then go to OUT.
  - Products are 8x14 signed. Sum is truncated to ACC_BITS with wrap; no saturation.
- OUT:
  - valid_out=1. data_out=acc[18:7], out_idx=o, last_out=(o==9).
  - These outputs are held stable until out_ready.
  - On handshake: if o==9, go to LOAD; else o<=o+1 and go to MAC.
- in_ready=0 in MAC and OUT. valid_in is ignored there; upstream must stall.
- w_addr and b_addr are don't-care outside MAC c=0..47. They are held at the last value.

## Timing
- Reset values: in_ready=1, valid_out=0, last_out=0, out_idx=0, data_out=0, w_addr=0, b_addr=0. Counters are 0.
- Buffer and acc are not reset. The buffer is fully rewritten each frame before use.
- Last input beat accepted at cycle T: MAC c=0 at T+1, valid_out first high at T+50.
- Handshake at cycle H: next class MAC c=0 at H+1, its valid_out at H+50. The final handshake at H gives in_ready=1 at H+1.
- With out_ready tied high, a frame takes 16 load beats plus 10×50 cycles.
- out_ready low: the score is held indefinitely, and nothing else advances.
- Reset asserted mid-MAC or mid-OUT: valid_out drops asynchronously. The partial frame is discarded and the block returns to LOAD, beat 0.

## Structure
- Package cnn_fc_pkg holds INPUT_NUM, OUTPUT_NUM, LANES, DATA_BITS, IN_BITS and ACC_BITS. It also holds the state enum {LOAD, MAC, OUT} and the output slice positions 18 and 7.
- One sub-module, fc_mac: signed 8x14 multiply with clear, bias-add and enable into a 20-bit wrapping accumulator.
- The sequencer FSM, buffer and address generation stay in fc_sequencer.

## Test plan
- All samples 12'h080, all weights 1, biases 0 -> ten scores 12'h030 with out_idx 0..9, last_out only on 9.
- All samples 12'hF80, weights 1, biases 0 -> every score 12'hFD0.
- Samples 12'h080, weights 2, bias -128 -> acc 12160, score 12'h05F.
- Samples 2047, weights 127, bias 0 -> wrapped acc 944176, score 12'hCD0, bit-exact with the golden model.
- out_ready low for 20 cycles on class 3 -> data_out and out_idx unchanged throughout. Class 4 valid 50 cycles after release. valid_in pulses are ignored, with in_ready=0.
- rst pulsed at MAC c=20 of class 5 -> valid_out=0 and in_ready=1 immediately. A fresh 16-beat frame then yields a correct 10-score sequence.
